// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU load/store port: latches one request, waits
// WAIT_CYCLES, then does a byte/half/word access on a local byte array and acks.
module mem_bus_responder #(
  parameter int unsigned MEM_BYTES   = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int unsigned ADDR_W = $clog2(MEM_BYTES);
  localparam int unsigned CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT             state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic              latWe, latWeNext;
  logic [1:0]        latSize, latSizeNext;
  logic [31:0]       latAddr, latAddrNext;
  logic [31:0]       latWdata, latWdataNext;
  logic              ackNext, errNext, busyNext;
  logic [31:0]       rdataNext;

  logic [7:0]        mem [MEM_BYTES];
  logic [ADDR_W-1:0] idx;
  logic [3:0]        laneEn;
  logic              accessErr;
  logic              doWrite;
  logic [31:0]       readWord;

  // Decode the latched request into byte lanes, an error flag and the read word.
  always_comb begin
    idx      = latAddr[ADDR_W-1:0];
    readWord = 32'h0;
    case (latSize)
      2'b00:   laneEn = 4'b1111;
      2'b01:   laneEn = 4'b0011;
      2'b10:   laneEn = 4'b0001;
      default: laneEn = 4'b0000;
    endcase
    accessErr = (latSize == 2'b11)
             || ((latSize == 2'b00) && (latAddr[1:0] != 2'b00))
             || ((latSize == 2'b01) && latAddr[0])
             || (latAddr >= 32'(MEM_BYTES));
    for (int k = 0; k < 4; k++) begin
      if (laneEn[k]) readWord[8*k +: 8] = mem[idx + ADDR_W'(k)];
    end
    doWrite = (state == WAIT) && (cnt == CNT_W'(0)) && latWe && !accessErr;
  end

  // Array storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      for (int k = 0; k < 4; k++) begin
        if (laneEn[k]) mem[idx + ADDR_W'(k)] <= latWdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      latWe    <= 1'b0;
      latSize  <= 2'b00;
      latAddr  <= 32'h0;
      latWdata <= 32'h0;
      ack      <= 1'b0;
      err      <= 1'b0;
      rdata    <= 32'h0;
      busy     <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      latWe    <= latWeNext;
      latSize  <= latSizeNext;
      latAddr  <= latAddrNext;
      latWdata <= latWdataNext;
      ack      <= ackNext;
      err      <= errNext;
      rdata    <= rdataNext;
      busy     <= busyNext;
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    latWeNext    = latWe;
    latSizeNext  = latSize;
    latAddrNext  = latAddr;
    latWdataNext = latWdata;
    ackNext      = 1'b0;
    errNext      = 1'b0;
    rdataNext    = rdata;
    busyNext     = busy;
    case (state)
      IDLE: begin
        if (req) begin
          latWeNext    = we;
          latSizeNext  = size;
          latAddrNext  = addr;
          latWdataNext = wdata;
          cntNext      = CNT_W'(WAIT_CYCLES);
          busyNext     = 1'b1;
          stateNext    = WAIT;
        end
      end
      WAIT: begin
        if (cnt != CNT_W'(0)) begin
          cntNext = cnt - CNT_W'(1);
        end else begin
          ackNext   = 1'b1;
          stateNext = RESP;
          if (accessErr) begin
            errNext   = 1'b1;
            rdataNext = 32'h0;
          end else if (!latWe) begin
            rdataNext = readWord;
          end
        end
      end
      RESP: begin
        busyNext  = 1'b0;
        stateNext = IDLE;
      end
      default: begin
        busyNext  = 1'b0;
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: byte-array reference model, random and
// directed requests, plus a zero-wait instance for back-to-back timing.
module tb_mem_bus_responder;

  localparam int unsigned MEM_BYTES = 256;
  localparam int unsigned W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ack, err, busy;
  logic [31:0] rdata;

  logic        req0, we0;
  logic [1:0]  size0;
  logic [31:0] addr0, wdata0;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  always #5 clk = ~clk;

  mem_bus_responder #(.MEM_BYTES(MEM_BYTES), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy));

  mem_bus_responder #(.MEM_BYTES(MEM_BYTES), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .size(size0), .addr(addr0),
    .wdata(wdata0), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0));

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } expT;

  expT         sb[$];
  logic [7:0]  refMem [MEM_BYTES];
  logic [31:0] lastR = 32'h0;
  int          nVec = 0;
  int          nErr = 0;
  int          cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: alignment/range rules and little-endian lanes on a byte array.
  task automatic model(input logic w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, output logic eErr, output logic [31:0] eR);
    int nb;
    nb = (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
    if (s == 2'd3 || (a % nb) != 0 || a >= MEM_BYTES) begin
      eErr  = 1'b1;
      eR    = 32'h0;
      lastR = 32'h0;
    end else if (w) begin
      eErr = 1'b0;
      for (int i = 0; i < nb; i++) refMem[a + i] = d[8*i +: 8];
      eR = lastR;
    end else begin
      eErr = 1'b0;
      eR   = 32'h0;
      for (int i = 0; i < nb; i++) eR = eR | (32'(refMem[a + i]) << (8 * i));
      lastR = eR;
    end
  endtask

  task automatic waitIdle(output logic ok);
    int budget = 0;
    @(negedge clk);
    while (busy !== 1'b0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    ok = (budget < 50);
    if (!ok) begin
      nVec++;
      nErr++;
      $display("FAIL idle_timeout: busy stayed %b for %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic doReq(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    logic ok;
    expT  e;
    waitIdle(ok);
    if (!ok) return;
    req = 1'b1; we = w; size = s; addr = a; wdata = d;
    @(posedge clk);
    #1;
    model(w, s, a, d, e.err, e.rdata);
    e.cyc = cyc + W + 1;
    sb.push_back(e);
    // Latched copies must be used, so scramble the bus after the sampling edge.
    req = 1'b0; we = ~w; size = 2'($urandom); addr = $urandom; wdata = $urandom;
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && ack === 1'b1) begin
      if (sb.size() == 0) begin
        nVec++;
        nErr++;
        $display("FAIL unexpected_ack: ack=1 with no request outstanding (cycle %0d)", cyc);
      end else begin
        expT e;
        e = sb.pop_front();
        check32("err", {31'b0, err}, {31'b0, e.err});
        check32("rdata", rdata, e.rdata);
        check32("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic ok;
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0;
    req0 = 1'b0; we0 = 1'b0; size0 = 2'b00; addr0 = 32'h0; wdata0 = 32'h0;
    #1;
    check32("reset_ack", {31'b0, ack}, 32'h0);
    check32("reset_err", {31'b0, err}, 32'h0);
    check32("reset_rdata", rdata, 32'h0);
    check32("reset_busy", {31'b0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < MEM_BYTES / 4; i++) doReq(1'b1, 2'd0, 32'(i * 4), $urandom);

    doReq(1'b1, 2'd0, 32'h10, 32'hDEADBEEF);
    doReq(1'b0, 2'd0, 32'h10, 32'h0);
    doReq(1'b1, 2'd2, 32'h13, 32'h000000AA);
    doReq(1'b0, 2'd0, 32'h10, 32'h0);
    doReq(1'b0, 2'd1, 32'h12, 32'h0);

    doReq(1'b0, 2'd1, 32'h11, 32'h0);
    doReq(1'b0, 2'd0, 32'h22, 32'h0);
    doReq(1'b0, 2'd3, 32'h00, 32'h0);
    doReq(1'b0, 2'd0, 32'(MEM_BYTES), 32'h0);
    doReq(1'b1, 2'd0, 32'(MEM_BYTES), 32'hFFFFFFFF);
    doReq(1'b1, 2'd1, 32'h11, 32'hFFFFFFFF);
    doReq(1'b1, 2'd2, 32'hFFFFFF10, 32'h55);
    doReq(1'b0, 2'd0, 32'h10, 32'h0);

    // Reset in the second WAIT cycle of a write: nothing commits, no ack.
    waitIdle(ok);
    req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check32("abort_ack", {31'b0, ack}, 32'h0);
    check32("abort_err", {31'b0, err}, 32'h0);
    check32("abort_rdata", rdata, 32'h0);
    check32("abort_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    lastR = 32'h0;
    doReq(1'b0, 2'd0, 32'h20, 32'h0);

    // A second request raised during WAIT must be ignored.
    doReq(1'b0, 2'd0, 32'h10, 32'h0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h40; wdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    req = 1'b0;
    doReq(1'b0, 2'd0, 32'h40, 32'h0);

    for (int i = 0; i < 150; i++) begin
      int unsigned r;
      logic [1:0]  s;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      s = (r == 9) ? 2'd3 : 2'(r % 3);
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'(MEM_BYTES) + $urandom_range(0, 1000);
      else if (r == 1) a = $urandom;
      else             a = $urandom_range(0, MEM_BYTES - 1);
      doReq(1'($urandom_range(0, 1)), s, a, $urandom);
    end

    // Zero-wait instance, req held for six edges: samples at n=0 and n=3.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; size0 = 2'd0; addr0 = 32'h0;
    for (int n = 0; n < 9; n++) begin
      logic sampledPrev, sampledNow, expAck, expBusy;
      @(posedge clk); #1;
      sampledNow  = (n % 3 == 0) && (n < 6);
      sampledPrev = (n >= 1) && ((n - 1) % 3 == 0) && (n - 1 < 6);
      expAck  = sampledPrev;
      expBusy = sampledNow || sampledPrev;
      check32($sformatf("b2b_ack_%0d", n), {31'b0, ack0}, {31'b0, expAck});
      check32($sformatf("b2b_busy_%0d", n), {31'b0, busy0}, {31'b0, expBusy});
      if (expAck) check32($sformatf("b2b_err_%0d", n), {31'b0, err0}, 32'h0);
      if (n == 5) req0 = 1'b0;
    end

    repeat (20) @(negedge clk);
    check32("outstanding", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
